// File: rtl/wb_regfile.sv
// wb_regfile: integer register file with post-reset clear sweep and WB write-through bypass; REGFILE_DEBUG_EN adds a debug read port and write counter
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWrite,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] WriteData,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            init_busy
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     wr_count
`endif
);
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [AW-1:0] init_ptr;
  logic [XLEN-1:0] mem [NREGS];
  logic wr_ok;
  assign wr_ok = ~init_busy & RegWrite;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= INIT;
      init_ptr  <= AW'(1);
      init_busy <= 1'b1;
    end else if (state == INIT) begin
      if (init_ptr == AW'(NREGS - 1)) begin
        state     <= READY;
        init_busy <= 1'b0;
      end else init_ptr <= init_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (init_busy) mem[init_ptr] <= '0;
    else if (RegWrite && rd_addr != '0) mem[rd_addr] <= WriteData;
  always_comb begin
    rs1_data = (init_busy || rs1_addr == '0) ? '0 :
               (wr_ok && rd_addr == rs1_addr) ? WriteData : mem[rs1_addr];
    rs2_data = (init_busy || rs2_addr == '0) ? '0 :
               (wr_ok && rd_addr == rs2_addr) ? WriteData : mem[rs2_addr];
  end
`ifdef REGFILE_DEBUG_EN
  always_comb
    dbg_data = (dbg_addr == '0) ? '0 :
               (wr_ok && rd_addr == dbg_addr) ? WriteData : mem[dbg_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_count <= '0;
    else if (wr_ok) wr_count <= wr_count + 1'b1;
`endif
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Integer register file that consumes the write-back result (WriteData) from the WB stage and serves the two decode-stage source operands.
- The storage array has no reset so it maps to distributed RAM.
- A post-reset init sweep clears x1..x31 and holds the core off via init_busy.
- Same-cycle write-through bypass keeps single-cycle read-after-write correct.

Parameters:
XLEN, 32, data width of each register and of WriteData.
NREGS, 32, number of architectural registers; x0 is hardwired zero.
AW, 5, register address width; must equal clog2(NREGS).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
RegWrite  in  1  write enable from control/WB.
rd_addr  in  AW  destination register index.
WriteData  in  XLEN  write-back value from the WB stage mux.
rs1_addr  in  AW  source 1 index.
rs2_addr  in  AW  source 2 index.
rs1_data  out  XLEN  source 1 operand, combinational.
rs2_data  out  XLEN  source 2 operand, combinational.
init_busy  out  1  high while the init sweep runs; the core must stall.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=INIT, init_ptr=1, init_busy=1. rs1_data and rs2_data are forced to 0 while init_busy=1.
- FSM has two states, INIT and READY.
- INIT, each rising edge:
  - array[init_ptr] <= 0.
  - If init_ptr==NREGS-1, go to READY and clear init_busy; otherwise init_ptr <= init_ptr+1.
  - Result: init_busy is high for exactly NREGS-1 (31) rising edges after rst_n deasserts, and falls on the edge that clears x31.
- INIT ignores the RegWrite/rd_addr/WriteData inputs entirely. The sweep has priority, and any write presented during INIT is dropped (not queued).
- READY write: on a rising edge with RegWrite=1 and rd_addr!=0, array[rd_addr] <= WriteData. Writes to x0 are discarded.
- READY read, rs1 (rs2 identical):
  - If rs1_addr==0, output 0.
  - Else if RegWrite=1 and rd_addr==rs1_addr, output WriteData (write-through bypass).
  - Else output array[rs1_addr].
- rs1 and rs2 naming the same register both bypass independently.
- Reset asserted mid-sweep or in READY: immediate return to INIT with init_ptr=1, and the sweep restarts from x1. Array contents are not touched asynchronously; the sweep overwrites them.
- Latency: read is 0 cycles (combinational); a write is visible from the array one edge later and via the bypass in the same cycle.
- No X propagation: every array entry except x0 is written before init_busy falls. x0 is never stored.

Optional Feature:
- Macro: REGFILE_DEBUG_EN.
- Defined: adds ports dbg_addr (in, AW) and dbg_data (out, XLEN), plus wr_count (out, 32).
  - dbg_data is a third combinational read port with the same x0 and bypass rules, but it is not forced to 0 during INIT; it shows raw array contents so the sweep can be observed.
  - wr_count counts accepted READY writes, including writes to x0. It resets to 0 on rst_n=0 and wraps at 2^32.
- Not defined: these ports and their logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset sweep: pulse rst_n low for 2 cycles, release, count rising edges until init_busy falls -> exactly 31. Then read rs1_addr=7 and rs2_addr=31 -> both read 0x00000000.
- Basic write/read: in READY write x5=0xDEADBEEF, next cycle RegWrite=0 and rs1_addr=5 -> rs1_data=0xDEADBEEF. rs2_addr=6 -> 0x00000000.
- Bypass: same cycle RegWrite=1, rd_addr=10, WriteData=0x00001004, rs1_addr=rs2_addr=10 -> both outputs read 0x00001004 before the edge. After the edge with RegWrite=0 -> both still read 0x00001004.
- x0 protection: write rd_addr=0 with WriteData=0xABCD0000 and rs1_addr=0 in the same cycle -> rs1_data=0 both during and after the edge.
- Write during INIT: drive RegWrite=1, rd_addr=3, WriteData=0x00001111 at edge 5 after reset release -> init_busy stays high. After READY, x3 reads 0.
- Reset mid-operation: write x9=0x12345678, assert rst_n low asynchronously between edges -> init_busy=1 and rs outputs=0 immediately. After release and 31 edges, x9 reads 0. With REGFILE_DEBUG_EN, wr_count=0 after reset and =1 after one further write.
